pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. It drives the stall and flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It resolves three hazards: load-use, taken-branch redirect from EX, and multi-cycle MEM-stage accesses. MEM-stage accesses are either fixed-latency block RAM or handshaked MMIO with a timeout.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_ctrl_pkg: shared state encoding and helpers           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    STATE_RUN      = 2'd0,
    STATE_WAIT_FIX = 2'd1,
    STATE_WAIT_IO  = 2'd2
  } state_e;

  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_IO_TIMEOUT = 255;
  localparam int DEF_CNT_W      = 8;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_ctrl_load_use_detect: load in EX feeding ID operand   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pipeline_hazard_ctrl_load_use_detect (
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  output logic       hit_o
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hit_o = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                 ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                  (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int IO_TIMEOUT = DEF_IO_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_is_mmio_i,
  input  logic        mem_ack_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_stall_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_stall_o,
  output logic        mem_wb_flush_o,
  output logic        timeout_err_o,
  output logic        err_sticky_o,
  output logic [31:0] stall_cycles_o
);

  localparam logic [CNT_W-1:0] c_lat_m1  = (MEM_LAT > 0) ? CNT_W'(MEM_LAT - 1) : '0;
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(IO_TIMEOUT);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_sticky_q;
  logic [31:0]        stall_cycles_q;

  logic w_memstall_raw, w_timeout_raw;
  logic w_memstall, w_timeout, w_lu_hit, w_branch, w_lu;

  pipeline_hazard_ctrl_load_use_detect u_lu (
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_i       (ex_rd_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .hit_o         (w_lu_hit)
  );

  always_comb begin
    w_memstall_raw = 1'b0;
    w_timeout_raw  = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    case (state_q)
      STATE_RUN: begin
        if (mem_req_i) begin
          if (!mem_is_mmio_i) begin
            if (MEM_LAT != 0) begin
              w_memstall_raw = 1'b1;
              state_d        = STATE_WAIT_FIX;
              cnt_d          = c_lat_m1;
            end
          end else if (!mem_ack_i) begin
            w_memstall_raw = 1'b1;
            state_d        = STATE_WAIT_IO;
            cnt_d          = c_one;
          end
        end
      end
      STATE_WAIT_FIX: begin
        // the release cycle returns to RUN without looking at mem_req again
        if (cnt_q != '0) begin
          w_memstall_raw = 1'b1;
          cnt_d          = cnt_q - c_one;
        end else begin
          state_d = STATE_RUN;
        end
      end
      STATE_WAIT_IO: begin
        if (mem_ack_i) begin
          state_d = STATE_RUN;
        end else if (cnt_q == c_timeout) begin
          w_timeout_raw = 1'b1;
          state_d       = STATE_RUN;
        end else begin
          w_memstall_raw = 1'b1;
          cnt_d          = cnt_q + c_one;
        end
      end
      default: state_d = STATE_RUN;
    endcase
  end

  assign w_memstall = w_memstall_raw & ~rst;
  assign w_timeout  = w_timeout_raw & ~rst;
  assign w_branch   = ex_branch_taken_i & ~w_memstall & ~rst;
  assign w_lu       = w_lu_hit & ~ex_branch_taken_i & ~w_memstall & ~rst;

  assign pc_stall_o     = w_memstall | w_lu;
  assign if_id_stall_o  = w_memstall | w_lu;
  assign if_id_flush_o  = w_branch;
  assign id_ex_stall_o  = w_memstall;
  assign id_ex_flush_o  = w_branch | w_lu;
  assign ex_mem_stall_o = w_memstall;
  assign mem_wb_flush_o = w_memstall;
  assign timeout_err_o  = w_timeout;
  assign err_sticky_o   = err_sticky_q;
  assign stall_cycles_o = stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= STATE_RUN;
      cnt_q          <= '0;
      err_sticky_q   <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_timeout) err_sticky_q <= 1'b1;
      if (w_memstall) stall_cycles_q <= sat_inc32(stall_cycles_q);
    end
  end

endmodule
`default_nettype wire
